control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 38 +++
 rtl/control_unit_if.sv | 26 ++
 rtl/control_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/control_unit_pkg.sv
// control_unit_pkg: opcodes, FSM state encoding and opcode classification
// shared by the control unit, the datapath and the bench.
package control_unit_pkg;
    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8,  OP_SHL  = 5'd9,  OP_ROR  = 5'd10, OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14, OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18, OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20, OP_JAL  = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26, OP_HALT = 5'd27;

    typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

    // Opcodes that share an identical execute sequence collapse to one class.
    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MUL, C_NEG, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT, C_NOP
    } cls_t;

    function automatic cls_t op_class(input logic [4:0] op);
        if (op == OP_LD) return C_LD;
        if (op == OP_LDI) return C_LDI;
        if (op == OP_ST) return C_ST;
        if (op >= OP_ADD && op <= OP_ROL) return C_ALU;
        if (op >= OP_ADDI && op <= OP_ORI) return C_IMM;
        if (op == OP_MUL || op == OP_DIV) return C_MUL;
        if (op == OP_NEG || op == OP_NOT) return C_NEG;
        if (op == OP_BR) return C_BR;
        if (op == OP_JR) return C_JR;
        if (op == OP_JAL) return C_JAL;
        if (op == OP_IN) return C_IN;
        if (op == OP_OUT) return C_OUT;
        if (op == OP_MFHI) return C_MFHI;
        if (op == OP_MFLO) return C_MFLO;
        if (op == OP_HALT) return C_HALT;
        return C_NOP;
    endfunction
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: datapath <-> control unit signals.
//   master: control unit (consumes IR/CON/Stop, drives Run and all control strobes)
//   slave : datapath side
interface control_unit_if;
    logic [31:0] IR;
    logic CON, Stop, Run;
    logic PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout;
    logic MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, HiIn, LoIn, CIn, InIn, OutIn, CONIn;
    logic IncPC, read, write;
    logic Gra, Grb, Grc, Rin, Rout, BAout;

    modport master (
        input  IR, CON, Stop,
        output Run,
        output PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout,
        output MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, HiIn, LoIn, CIn, InIn, OutIn, CONIn,
        output IncPC, read, write, Gra, Grb, Grc, Rin, Rout, BAout
    );
    modport slave (
        output IR, CON, Stop,
        input  Run,
        input  PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout,
        input  MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, HiIn, LoIn, CIn, InIn, OutIn, CONIn,
        input  IncPC, read, write, Gra, Grb, Grc, Rin, Rout, BAout
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing fetch (T0-T2) and per-opcode execute (T3-T7).
//   clk : rising-edge clock
//   clr : asynchronous active-low reset (forces RST, all outputs 0)
//   bus : control_unit_if.master (IR/CON/Stop in, Run and control strobes out)
module control_unit
    import control_unit_pkg::*;
(
    input  logic clk,
    input  logic clr,
    control_unit_if.master bus
);
    state_t state, nxt, fin;
    cls_t cls;
    logic last;

    assign cls = op_class(bus.IR[31:27]);

    // Final state of each execute sequence; T7 always ends one.
    assign last = (state == T3 && cls inside {C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP})
               || (state == T4 && cls inside {C_NEG, C_JAL})
               || (state == T5 && cls inside {C_ALU, C_IMM, C_LDI})
               || (state == T6 && cls inside {C_MUL, C_BR})
               || state == T7;

    always_ff @(posedge clk or negedge clr)
        if (!clr) state <= RST;
        else state <= nxt;

    // Stop only matters on the way back into T0, so instructions always finish.
    always_comb begin
        fin = bus.Stop ? HALT : T0;
        case (state)
            RST:     nxt = fin;
            HALT:    nxt = HALT;
            T3:      nxt = cls == C_HALT ? HALT : last ? fin : T4;
            default: nxt = last ? fin : state_t'(state + 4'd1);
        endcase
    end

    always_comb begin
        {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.Cout, bus.In_Portout, bus.LOout, bus.HIout,
         bus.MARIn, bus.ZIn, bus.PCIn, bus.MDRIn, bus.IRIn, bus.YIn, bus.HiIn, bus.LoIn, bus.CIn, bus.InIn,
         bus.OutIn, bus.CONIn, bus.IncPC, bus.read, bus.write,
         bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout} = '0;
        bus.Run = state != RST && state != HALT;
        case (state)
            T0: {bus.PCout, bus.MARIn, bus.IncPC, bus.ZIn} = '1;
            T1: {bus.Zlowout, bus.PCIn, bus.read, bus.MDRIn} = '1;
            T2: {bus.MDRout, bus.IRIn} = '1;
            T3: case (cls)
                C_ALU, C_IMM:      {bus.Grb, bus.Rout, bus.YIn} = '1;
                C_LDI, C_LD, C_ST: {bus.Grb, bus.BAout, bus.YIn} = '1;
                C_MUL:             {bus.Gra, bus.Rout, bus.YIn} = '1;
                C_NEG:             {bus.Grb, bus.Rout, bus.ZIn} = '1;
                C_BR:              {bus.Gra, bus.Rout, bus.CONIn} = '1;
                C_JR:              {bus.Gra, bus.Rout, bus.PCIn} = '1;
                C_JAL:             {bus.PCout, bus.Grb, bus.Rin} = '1;
                C_IN:              {bus.In_Portout, bus.Gra, bus.Rin} = '1;
                C_OUT:             {bus.Gra, bus.Rout, bus.OutIn} = '1;
                C_MFHI:            {bus.HIout, bus.Gra, bus.Rin} = '1;
                C_MFLO:            {bus.LOout, bus.Gra, bus.Rin} = '1;
                default: ;
            endcase
            T4: case (cls)
                C_ALU:                    {bus.Grc, bus.Rout, bus.ZIn} = '1;
                C_IMM, C_LDI, C_LD, C_ST: {bus.Cout, bus.ZIn} = '1;
                C_MUL:                    {bus.Grb, bus.Rout, bus.ZIn} = '1;
                C_NEG:                    {bus.Zlowout, bus.Gra, bus.Rin} = '1;
                C_BR:                     {bus.PCout, bus.YIn} = '1;
                C_JAL:                    {bus.Gra, bus.Rout, bus.PCIn} = '1;
                default: ;
            endcase
            T5: case (cls)
                C_ALU, C_IMM, C_LDI: {bus.Zlowout, bus.Gra, bus.Rin} = '1;
                C_LD, C_ST:          {bus.Zlowout, bus.MARIn} = '1;
                C_MUL:               {bus.Zlowout, bus.LoIn} = '1;
                C_BR:                {bus.Cout, bus.ZIn} = '1;
                default: ;
            endcase
            T6: case (cls)
                C_LD:  {bus.read, bus.MDRIn} = '1;
                C_ST:  {bus.Gra, bus.Rout, bus.MDRIn} = '1;
                C_MUL: {bus.Zhighout, bus.HiIn} = '1;
                C_BR:  begin
                    bus.Zlowout = 1'b1;
                    bus.PCIn = bus.CON;
                end
                default: ;
            endcase
            T7: case (cls)
                C_LD: {bus.MDRout, bus.Gra, bus.Rin} = '1;
                C_ST: bus.write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end
endmodule
